// File: rtl/adder_tree_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_tree_scheduler_pkg -- shared defaults, tag type, FSM encoding   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adder_tree_scheduler_pkg;

   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_TREE_SIZE    = 8;
   localparam int DEF_TREE_LATENCY = 3;

   // Wide enough for the largest supported requester count (16).
   localparam int TAG_ID_W = 4;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   typedef struct packed {
      logic                valid;
      logic                first;
      logic                last;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage
`default_nettype wire

// File: rtl/adder_tree_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter -- picks the first request at or after ptr (circular)      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter
   import adder_tree_scheduler_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    id
);

   localparam logic [ID_W:0] NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);

   logic [ID_W:0] idx;
   logic          found;

   always_comb begin
      grant = '0;
      id    = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // ptr < NUM_REQ, so one conditional subtract is enough to wrap.
         idx = {1'b0, ptr} + (ID_W+1)'(i);
         if (idx >= NUM_REQ_EXT) begin
            idx = idx - NUM_REQ_EXT;
         end
         if (enable && !found && req[idx[ID_W-1:0]]) begin
            found                = 1'b1;
            id                   = idx[ID_W-1:0];
            grant[idx[ID_W-1:0]] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/adder_tree_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_tree_scheduler -- round-robin packet sharing of an adder tree   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder_tree_scheduler
   import adder_tree_scheduler_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int TREE_SIZE    = DEF_TREE_SIZE,
   parameter int TREE_LATENCY = DEF_TREE_LATENCY,
   parameter int ID_W         = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_last,
   input  logic [NUM_REQ*TREE_SIZE*32-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [TREE_SIZE*32-1:0]        tree_in,
   input  logic [31:0]                    tree_out,
   output logic                           rsp_valid,
   output logic [ID_W-1:0]                rsp_id,
   output logic [31:0]                    rsp_data
);

   localparam int             BEAT_W  = TREE_SIZE*32;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ-1);

   logic [0:0]         state;
   logic [ID_W-1:0]    owner;
   logic [ID_W-1:0]    rr_ptr;
   logic               first_pending;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               any_grant;
   logic               accept;
   tag_t               push_tag;
   tag_t               tags [TREE_LATENCY+1];
   tag_t               aligned;
   logic [31:0]        acc;
   logic [31:0]        sum;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .enable (state == ST_IDLE),
      .grant  (grant),
      .id     (grant_id)
   );

   assign any_grant = |grant;
   assign accept    = (state == ST_BURST) && req_valid[owner];
   assign req_ready = (state == ST_BURST) ? (NUM_REQ'(1) << owner) : '0;

   always_comb begin
      push_tag = '0;
      if (accept) begin
         push_tag.valid = 1'b1;
         push_tag.first = first_pending;
         push_tag.last  = req_last[owner];
         push_tag.id    = TAG_ID_W'(owner);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         owner         <= '0;
         rr_ptr        <= '0;
         first_pending <= 1'b0;
         tree_in       <= '0;
      end else if (state == ST_IDLE) begin
         if (any_grant) begin
            owner         <= grant_id;
            rr_ptr        <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            first_pending <= 1'b1;
            state         <= ST_BURST;
         end
      end else if (accept) begin
         tree_in       <= req_data[int'(owner)*BEAT_W +: BEAT_W];
         first_pending <= 1'b0;
         if (req_last[owner]) begin
            state <= ST_IDLE;
         end
      end
   end

   // One tag per cycle (bubble when nothing accepted) keeps tags aligned with tree_out.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s <= TREE_LATENCY; s++) begin
            tags[s] <= '0;
         end
      end else begin
         tags[0] <= push_tag;
         for (int s = 1; s <= TREE_LATENCY; s++) begin
            tags[s] <= tags[s-1];
         end
      end
   end

   assign aligned = tags[TREE_LATENCY];
   assign sum     = (aligned.first ? 32'd0 : acc) + tree_out;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         acc       <= '0;
      end else begin
         rsp_valid <= aligned.valid && aligned.last;
         if (aligned.valid) begin
            if (aligned.last) begin
               rsp_data <= sum;
               rsp_id   <= ID_W'(aligned.id);
               acc      <= '0;
            end else begin
               acc <= sum;
            end
         end
      end
   end

endmodule
`default_nettype wire
